sram_ctrl_burst: RTL and testbench

Single-clock, parametrised successor to the dual-clock asynchronous-SRAM controller. It adds configurable data width with per-byte lane enables (generalising ub/lb), programmable read and write wait states, and incrementing bursts of 1..2^BURST_W words. It sits between the host request logic (mem/rw/addr/data_f2s) and one external async SRAM chip (ad/dio/ce_n/oe_n/we_n/be_n).

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_dio_pad.sv | 15 +
 rtl/sram_ctrl_burst.sv | 160 ++++++++++++++++
 tb/tb_sram_ctrl_burst.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the burst SRAM controller: FSM state encoding,
// wait-state counter width and the byte-lane count derivation.
package sram_ctrl_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACT,
    RD_CAP,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_dio_pad.sv
// Bidirectional SRAM data pad: the only tristate in the design, plus an
// unregistered tap of whatever is currently on the bus.
module sram_dio_pad #(
  parameter int DATA_W = 16
) (
  input  logic              drive_en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] dio
);

  assign dio = drive_en ? dout : {DATA_W{1'bz}};
  assign din = dio;

endmodule

// File: rtl/sram_ctrl_burst.sv
// Single-clock async-SRAM controller with byte lanes, programmable read/write
// wait states and incrementing bursts; every SRAM pin is driven from a flop.
module sram_ctrl_burst
  import sram_ctrl_pkg::*;
#(
  parameter  int ADDR_W  = 18,
  parameter  int DATA_W  = 16,
  parameter  int RD_WAIT = 1,
  parameter  int WR_WAIT = 1,
  parameter  int BURST_W = 3,
  localparam int BE_W    = be_width(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem,
  input  logic               rw,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [BE_W-1:0]    be,
  input  logic [DATA_W-1:0]  data_f2s,
  output logic               ready,
  output logic               wdata_ack,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  data_s2f_r,
  output logic [DATA_W-1:0]  data_s2f_ur,
  output logic [ADDR_W-1:0]  ad,
  output logic               we_n,
  output logic               oe_n,
  output logic               ce_n,
  output logic [BE_W-1:0]    be_n,
  inout  wire  [DATA_W-1:0]  dio
);

  localparam logic [WAIT_W-1:0] RD_WAIT_C = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_WAIT_C = WAIT_W'(WR_WAIT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [BURST_W-1:0]  beats_q, beats_d;
  logic [ADDR_W-1:0]   ad_d;
  logic [BE_W-1:0]     be_q, be_d, be_n_d;
  logic [DATA_W-1:0]   dout_q, din;
  logic                drive_q, drive_d;
  logic                ce_n_d, oe_n_d, we_n_d;
  logic                load_wdata, capture, accept, rd_bus_low;

  // The final RD_CAP already has the pins parked idle, so it can accept.
  assign ready       = (state_q == IDLE) || (state_q == RD_CAP && beats_q == '0);
  assign accept      = ready && mem;
  assign wdata_ack   = (state_q == WR_SETUP);
  assign rd_valid    = (state_q == RD_CAP);
  assign data_s2f_ur = din;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beats_d = beats_q;
    ad_d    = ad;
    be_d    = be_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
      end
      RD_ACT: begin
        if (wait_q == '0) begin
          state_d = RD_CAP;
          capture = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RD_CAP: begin
        if (beats_q != '0) begin
          state_d = RD_ACT;
          wait_d  = RD_WAIT_C;
          beats_d = beats_q - 1'b1;
          ad_d    = ad + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        wait_d  = WR_WAIT_C;
      end
      WR_PULSE: begin
        if (wait_q == '0) state_d = WR_HOLD;
        else              wait_d  = wait_q - 1'b1;
      end
      WR_HOLD: begin
        if (beats_q != '0) begin
          state_d = WR_SETUP;
          beats_d = beats_q - 1'b1;
          ad_d    = ad + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = rw ? RD_ACT : WR_SETUP;
      wait_d  = RD_WAIT_C;
      beats_d = burst_len;
      ad_d    = addr;
      be_d    = be;
    end

    // Pin values are derived from the next state so they leave the flops aligned with it.
    load_wdata = (state_d == WR_SETUP);
    rd_bus_low = (state_d == RD_ACT) || (state_d == RD_CAP && beats_d != '0);
    drive_d    = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    oe_n_d     = !rd_bus_low;
    ce_n_d     = !(rd_bus_low || drive_d);
    we_n_d     = (state_d != WR_PULSE);
    be_n_d     = ce_n_d ? '1 : ~be_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      beats_q    <= '0;
      be_q       <= '0;
      ad         <= '0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      be_n       <= '1;
      drive_q    <= 1'b0;
      dout_q     <= '0;
      data_s2f_r <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beats_q <= beats_d;
      be_q    <= be_d;
      ad      <= ad_d;
      ce_n    <= ce_n_d;
      oe_n    <= oe_n_d;
      we_n    <= we_n_d;
      be_n    <= be_n_d;
      drive_q <= drive_d;
      if (load_wdata) dout_q     <= data_f2s;
      if (capture)    data_s2f_r <= din;
    end
  end

  sram_dio_pad #(
    .DATA_W(DATA_W)
  ) u_dio_pad (
    .drive_en(drive_q),
    .dout    (dout_q),
    .din     (din),
    .dio     (dio)
  );

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Scoreboard bench for sram_ctrl_burst: a pin-level SRAM model on the bus and a
// word-level reference memory that predicts every read beat and write beat.
module tb_sram_ctrl_burst;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;
  localparam int BURST_W = 3;
  localparam int BE_W    = DATA_W / 8;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef struct {
    bit                is_read;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mem = 1'b0;
  logic               rw = 1'b0;
  logic [ADDR_W-1:0]  addr = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [BE_W-1:0]    be = '0;
  logic [DATA_W-1:0]  data_f2s = '0;
  logic               ready, wdata_ack, rd_valid;
  logic [DATA_W-1:0]  data_s2f_r, data_s2f_ur;
  logic [ADDR_W-1:0]  ad;
  logic               we_n, oe_n, ce_n;
  logic [BE_W-1:0]    be_n;
  wire  [DATA_W-1:0]  dio;

  int checks = 0;
  int passes = 0;

  exp_t              sb[$];
  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] sram [DEPTH] = '{default: '0};

  always #5 clk = ~clk;

  sram_ctrl_burst #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT),
    .BURST_W(BURST_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (mem),
    .rw         (rw),
    .addr       (addr),
    .burst_len  (burst_len),
    .be         (be),
    .data_f2s   (data_f2s),
    .ready      (ready),
    .wdata_ack  (wdata_ack),
    .rd_valid   (rd_valid),
    .data_s2f_r (data_s2f_r),
    .data_s2f_ur(data_s2f_ur),
    .ad         (ad),
    .we_n       (we_n),
    .oe_n       (oe_n),
    .ce_n       (ce_n),
    .be_n       (be_n),
    .dio        (dio)
  );

  // Async SRAM: drives enabled lanes while selected for read, commits a write on we_n rising.
  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    assign dio[8*l +: 8] = (!ce_n && !oe_n && we_n && !be_n[l]) ? sram[ad][8*l +: 8] : 8'bz;
  end

  logic [DATA_W-1:0] wbuf;
  logic [ADDR_W-1:0] wad;
  logic [BE_W-1:0]   wlanes;
  bit                wpend = 0;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      wbuf   = dio;
      wad    = ad;
      wlanes = ~be_n;
      wpend  = 1;
    end else if (wpend) begin
      if (!ce_n)
        for (int l = 0; l < BE_W; l++)
          if (wlanes[l]) sram[wad][8*l +: 8] = wbuf[8*l +: 8];
      wpend = 0;
    end
  end

  // Host write-data feeder: moves on to the next beat the cycle after wdata_ack.
  bit adv = 0;
  always @(negedge clk) begin
    if (adv) begin
      if (wq.size() > 0) void'(wq.pop_front());
      adv = 0;
    end
    if (wdata_ack) adv = 1;
    data_f2s = (wq.size() > 0) ? wq[0] : '0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [DATA_W-1:0] laneMask(input logic [BE_W-1:0] b);
    logic [DATA_W-1:0] m = '0;
    for (int l = 0; l < BE_W; l++) if (b[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] refWord(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // Monitor: every ack / valid pulse must match the oldest expected beat.
  exp_t              e;
  logic [ADDR_W-1:0] last_rd_ad = '0;
  logic [BE_W-1:0]   exp_ben;
  logic [DATA_W-1:0] msk;

  always @(negedge clk) begin
    if (!reset) begin
      if (!oe_n && !ce_n) last_rd_ad = ad;
      if (wdata_ack) begin
        checkOutput("sb_nonempty_at_wdata_ack", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          exp_ben = ~e.be;
          checkOutput("beat_is_write", 64'(e.is_read), 0);
          checkOutput("wr_ad", ad, e.addr);
          checkOutput("wr_be_n", be_n, exp_ben);
        end
      end
      if (rd_valid) begin
        checkOutput("sb_nonempty_at_rd_valid", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          msk = laneMask(e.be);
          checkOutput("beat_is_read", 64'(e.is_read), 1);
          checkOutput("rd_ad", last_rd_ad, e.addr);
          checkOutput("rd_data", data_s2f_r & msk, e.data & msk);
        end
      end
    end
  end

  // Waits for ready, predicts every beat of the request, then presents it for one accept edge.
  task automatic issueRequest(input bit r, input logic [ADDR_W-1:0] a, input int blen,
                              input logic [BE_W-1:0] b, input bit rnd,
                              input logic [DATA_W-1:0] d0, input bit commit);
    int t = 0;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] d, w;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("ready_before_request", 64'(ready), 1);
    for (int i = 0; i <= blen; i++) begin
      ba = a + ADDR_W'(i);
      if (r) begin
        sb.push_back('{1'b1, ba, b, refWord(ba)});
      end else begin
        d = rnd ? DATA_W'($urandom) : DATA_W'(d0 * (i + 1));
        wq.push_back(d);
        if (commit) begin
          w = refWord(ba);
          for (int l = 0; l < BE_W; l++) if (b[l]) w[8*l +: 8] = d[8*l +: 8];
          ref_mem[int'(ba)] = w;
        end
        sb.push_back('{1'b0, ba, b, d});
      end
    end
    @(negedge clk);
    mem       = 1'b1;
    rw        = r;
    addr      = a;
    burst_len = BURST_W'(blen);
    be        = b;
    @(posedge clk);
  endtask

  // Holds mem for up to 'hold' extra cycles, then measures latency and strobe widths.
  task automatic waitDone(input bit r, input int blen, input int hold);
    int k = 0, oe_cnt = 0, we_cnt = 0, n = blen + 1;
    bit done = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      if (!oe_n) oe_cnt++;
      if (!we_n) we_cnt++;
      if (ready) done = 1;
      if (ready || k > hold) mem = 1'b0;
    end
    mem = 1'b0;
    checkOutput(r ? "rd_latency" : "wr_latency", 64'(k),
                64'(r ? n * (RD_WAIT + 2) : n * (WR_WAIT + 3) + 1));
    checkOutput("oe_low_cycles", 64'(oe_cnt), 64'(r ? n * (RD_WAIT + 2) - 1 : 0));
    checkOutput("we_low_cycles", 64'(we_cnt), 64'(r ? 0 : n * (WR_WAIT + 1)));
  endtask

  task automatic applyStimulus(input bit r, input logic [ADDR_W-1:0] a, input int blen,
                               input logic [BE_W-1:0] b, input bit rnd,
                               input logic [DATA_W-1:0] d0, input int hold);
    issueRequest(r, a, blen, b, rnd, d0, 1'b1);
    waitDone(r, blen, hold);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   ones = '1;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 1);
    checkOutput("reset_ce_oe_we", {ce_n, oe_n, we_n}, 3'b111);
    checkOutput("reset_be_n", be_n, ones);
    checkOutput("reset_ad", ad, 0);
    checkOutput("reset_data_s2f_r", data_s2f_r, 0);
    checkOutput("reset_pulses", {rd_valid, wdata_ack}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    // Abort a write in the middle of its we_n pulse.
    issueRequest(1'b0, 18'h00123, 0, '1, 1'b0, 16'h5A5A, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      mem = 1'b0;
      t++;
    end while (we_n && t < 50);
    checkOutput("we_low_before_reset", 64'(we_n), 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_ce_oe_we", {ce_n, oe_n, we_n}, 3'b111);
    checkOutput("abort_ready", 64'(ready), 1);
    checkOutput("abort_be_n", be_n, ones);
    checkOutput("abort_ad", ad, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_sram_word_unchanged", sram[18'h00123], 0);

    applyStimulus(1'b0, 18'h000F0, 0, 2'b11, 1'b0, 16'h00F0, 0);
    applyStimulus(1'b1, 18'h000F0, 0, 2'b11, 1'b0, '0, 0);

    applyStimulus(1'b0, 18'h00200, 0, 2'b11, 1'b0, 16'hABCD, 0);
    applyStimulus(1'b0, 18'h00200, 0, 2'b01, 1'b0, 16'h1234, 0);
    applyStimulus(1'b1, 18'h00200, 0, 2'b11, 1'b0, '0, 0);

    applyStimulus(1'b0, 18'h3FFFE, 3, 2'b11, 1'b0, 16'h1111, 0);
    applyStimulus(1'b1, 18'h3FFFE, 3, 2'b11, 1'b0, '0, 1000);

    applyStimulus(1'b1, 18'h00200, 1, 2'b00, 1'b0, '0, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       a = ADDR_W'(DEPTH - 1 - int'($urandom_range(0, 3)));
        1:       a = ADDR_W'(32'h100 + $urandom_range(0, 15));
        default: a = ADDR_W'($urandom);
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, int'($urandom_range(0, (1 << BURST_W) - 1)),
                    BE_W'($urandom), 1'b1, '0, int'($urandom_range(0, 8)));
    end

    t = 0;
    while (sb.size() > 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 0);
    foreach (ref_mem[k]) checkOutput("final_sram_word", sram[k], ref_mem[k]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
